key_debouncer: RTL



---
 rtl/key_debouncer_if.sv | 24 ++
 rtl/key_debouncer.sv | 75 +++++++
 2 files changed

// File: rtl/key_debouncer_if.sv
// Key conditioning bus: raw pins in, debounced level and edge strobes out.
// master = pin/board side and consumer, slave = the debouncer itself.
interface key_debouncer_if #(
   parameter int KEY_W = 4
);
   logic [KEY_W-1:0] key_i;
   logic [KEY_W-1:0] key_o;
   logic [KEY_W-1:0] key_press_o;
   logic [KEY_W-1:0] key_release_o;

   modport master (
      output key_i,
      input  key_o,
      input  key_press_o,
      input  key_release_o
   );

   modport slave (
      input  key_i,
      output key_o,
      output key_press_o,
      output key_release_o
   );
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-FF synchroniser followed by a saturating-window debounce counter,
// producing a clean pressed level plus registered one-cycle press/release strobes.
module key_debouncer #(
   parameter int KEY_W           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic            clk50m_i,
   input  logic            rst_n_i,
   key_debouncer_if.slave  key_if
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Sync flops idle at the released pin level so reset never looks like a press.
   localparam logic [KEY_W-1:0] SYNC_INIT = (ACTIVE_LOW != 0) ? {KEY_W{1'b1}} : {KEY_W{1'b0}};

   logic [KEY_W-1:0] s1_q, s1_d;
   logic [KEY_W-1:0] s2_q, s2_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [KEY_W-1:0] press_q, press_d;
   logic [KEY_W-1:0] release_q, release_d;
   logic [CNT_W-1:0] cnt_q [KEY_W];
   logic [CNT_W-1:0] cnt_d [KEY_W];
   logic [KEY_W-1:0] norm;

   always_comb begin
      s1_d      = key_if.key_i;
      s2_d      = s1_q;
      norm      = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
      key_d     = key_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < KEY_W; i++) begin
         cnt_d[i] = cnt_q[i];
         if (norm[i] == key_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            key_d[i]     = norm[i];
            cnt_d[i]     = '0;
            press_d[i]   = norm[i];
            release_d[i] = ~norm[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q      <= SYNC_INIT;
         s2_q      <= SYNC_INIT;
         key_q     <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < KEY_W; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         key_q     <= key_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < KEY_W; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign key_if.key_o         = key_q;
   assign key_if.key_press_o   = press_q;
   assign key_if.key_release_o = release_q;

endmodule
